// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: sequential Y86-64 fetch stage.
// Owns the architectural PC, reads the instruction at PC one byte at a time
// over a req/ack byte port, decodes icode/ifun/rA/rB/valC/valP, and holds the
// result (instr_valid) until the PC-update stage pulses pc_load.
// Optional feature macro: IMEM_BOUND_CHECK_EN (stop fetching at IMEM_SIZE and
// flag imem_error).
//
// Handshake: while in FETCH, imem_req stays high with a stable imem_addr until
// a cycle with imem_ack=1; that cycle transfers imem_rdata (zero-wait acks give
// one byte per cycle). imem_ack while imem_req=0 is ignored.
module y86_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [63:0] newpc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        instr_invalid,
  output logic        imem_error
);

`ifdef IMEM_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic {FETCH = 1'b0, DONE = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  byte_idx;
  logic [7:0]  byte_buf [0:9];

  // Merged view of the instruction bytes: stored bytes plus the byte arriving now.
  logic [7:0]  cur [0:9];
  logic [63:0] fetch_addr;
  logic        bound_hit;
  logic        take;
  logic        last;
  logic        finish;
  logic [3:0]  avail;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_len;
  logic [3:0]  f_ra;
  logic [3:0]  f_rb;
  logic [63:0] f_valc;
  logic [63:0] f_valp;
  logic        f_invalid;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  // Request generation, byte merge and field decode of the instruction in flight.
  always_comb begin
    fetch_addr = pc + {60'b0, byte_idx};
    bound_hit  = BOUND_EN && (state == FETCH) && (fetch_addr >= 64'(IMEM_SIZE));
    imem_req   = (state == FETCH) && !bound_hit;
    imem_addr  = fetch_addr;
    take       = imem_req && imem_ack;

    for (int i = 0; i < 10; i++) begin
      cur[i] = byte_buf[i];
      if (take && (byte_idx == 4'(i))) cur[i] = imem_rdata;
    end

    // Unfetched slots are zero (buffer cleared per instruction), so a bound stop
    // before byte0 decodes as icode 0 with length 1, giving valP = pc + 1.
    f_icode   = cur[0][7:4];
    f_ifun    = cur[0][3:0];
    f_len     = instr_len(f_icode);
    avail     = byte_idx + {3'b0, take};
    f_invalid = (f_icode > 4'hB);
    f_ra      = 4'hF;
    f_rb      = 4'hF;
    if (has_regs(f_icode) && (avail >= 4'd2)) begin
      f_ra = cur[1][7:4];
      f_rb = cur[1][3:0];
    end
    case (f_icode)
      4'h3, 4'h4, 4'h5: f_valc = {cur[9], cur[8], cur[7], cur[6], cur[5], cur[4], cur[3], cur[2]};
      4'h7, 4'h8:       f_valc = {cur[8], cur[7], cur[6], cur[5], cur[4], cur[3], cur[2], cur[1]};
      default:          f_valc = 64'h0;
    endcase
    f_valp = pc + {60'b0, f_len};

    last   = take && (byte_idx == (f_len - 4'd1));
    finish = last || bound_hit;
  end

  // Next-state logic: FETCH until the last byte (or a bound stop), DONE until pc_load.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (finish)  state_next = DONE;
      DONE:    if (pc_load) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Datapath: PC, byte buffer and registered decode outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      byte_idx      <= 4'd0;
      icode         <= 4'h0;
      ifun          <= 4'h0;
      rA            <= 4'hF;
      rB            <= 4'hF;
      valC          <= 64'h0;
      valP          <= 64'h0;
      instr_valid   <= 1'b0;
      instr_invalid <= 1'b0;
      imem_error    <= 1'b0;
      for (int i = 0; i < 10; i++) byte_buf[i] <= 8'h0;
    end else if (state == FETCH) begin
      if (take) begin
        for (int i = 0; i < 10; i++) begin
          if (byte_idx == 4'(i)) byte_buf[i] <= imem_rdata;
        end
        byte_idx <= byte_idx + 4'd1;
      end
      if (finish) begin
        icode         <= f_icode;
        ifun          <= f_ifun;
        rA            <= f_ra;
        rB            <= f_rb;
        valC          <= f_valc;
        valP          <= f_valp;
        instr_valid   <= 1'b1;
        instr_invalid <= f_invalid && !bound_hit;
        imem_error    <= bound_hit;
      end
    end else if (pc_load) begin
      pc            <= newpc_in;
      byte_idx      <= 4'd0;
      instr_valid   <= 1'b0;
      instr_invalid <= 1'b0;
      imem_error    <= 1'b0;
      for (int i = 0; i < 10; i++) byte_buf[i] <= 8'h0;
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb_y86_fetch_unit: directed bench for the Y86-64 fetch stage.
// A byte memory responder acks requests with a programmable delay and checks
// each acked address against an expected-address queue filled by the stimulus.
module tb_y86_fetch_unit;

`ifdef IMEM_BOUND_CHECK_EN
  localparam int MEM_BYTES = 16;
`else
  localparam int MEM_BYTES = 1024;
`endif

  logic        clk;
  logic        reset;
  logic        pc_load;
  logic [63:0] newpc_in;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        instr_invalid;
  logic        imem_error;

  logic [7:0]  mem [0:255];
  logic [63:0] exp_q[$];
  int          ack_delay;
  int          n_checks;
  int          n_pass;

  y86_fetch_unit #(.RESET_PC(64'h0), .IMEM_SIZE(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .newpc_in(newpc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .icode(icode), .ifun(ifun), .rA(rA),
    .rB(rB), .valC(valC), .valP(valP), .instr_valid(instr_valid),
    .instr_invalid(instr_invalid), .imem_error(imem_error)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(i));
  endtask

  task automatic load_pc(input logic [63:0] npc, input int n);
    pc_load  = 1'b1;
    newpc_in = npc;
    push_addrs(npc, n);
    tick();
    pc_load  = 1'b0;
    check64("load_valid_drop", {63'b0, instr_valid}, 64'd0);
    check64("load_invalid_drop", {63'b0, instr_invalid}, 64'd0);
    check64("load_pc", pc, npc);
  endtask

  task automatic wait_valid(input string tag, input int limit, input int exp_cycles);
    int cycles;
    cycles = 0;
    while (instr_valid !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
    if (instr_valid !== 1'b1) begin
      n_checks++;
      $error("FAIL %s_timeout observed=no instr_valid expected=instr_valid within %0d cycles", tag, limit);
    end else begin
      check64({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
    end
  endtask

  task automatic check_fields(input string tag, input logic [3:0] e_icode, input logic [3:0] e_ifun,
                              input logic [3:0] e_ra, input logic [3:0] e_rb, input logic [63:0] e_valc,
                              input logic [63:0] e_valp, input logic e_inv, input logic e_err);
    check64({tag, "_icode"}, {60'b0, icode}, {60'b0, e_icode});
    check64({tag, "_ifun"}, {60'b0, ifun}, {60'b0, e_ifun});
    check64({tag, "_rA"}, {60'b0, rA}, {60'b0, e_ra});
    check64({tag, "_rB"}, {60'b0, rB}, {60'b0, e_rb});
    check64({tag, "_valC"}, valC, e_valc);
    check64({tag, "_valP"}, valP, e_valp);
    check64({tag, "_invalid"}, {63'b0, instr_invalid}, {63'b0, e_inv});
    check64({tag, "_imem_error"}, {63'b0, imem_error}, {63'b0, e_err});
    check64({tag, "_req_low"}, {63'b0, imem_req}, 64'd0);
  endtask

  // Memory responder: acks after ack_delay wait cycles, checks acked addresses
  // against exp_q and address stability during waits; throws stray acks when idle.
  initial begin
    int          cnt;
    logic        waiting;
    logic [63:0] prev_addr;
    cnt        = 0;
    waiting    = 1'b0;
    prev_addr  = 64'h0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (waiting && !reset) check64("addr_stable", imem_addr, prev_addr);
        if (cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[7:0]];
          cnt        = 0;
          waiting    = 1'b0;
          if (!reset) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $error("FAIL unexpected_req observed=%h expected=no request", imem_addr);
            end else begin
              check64("req_addr", imem_addr, exp_q.pop_front());
            end
          end
        end else begin
          imem_ack  = 1'b0;
          cnt++;
          waiting   = 1'b1;
          prev_addr = imem_addr;
        end
        if (reset) begin
          waiting = 1'b0;
          cnt     = 0;
        end
      end else begin
        cnt        = 0;
        waiting    = 1'b0;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = 8'($urandom_range(0, 255));
      end
    end
  end

  // Directed stimulus.
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    ack_delay = 0;
    reset     = 1'b1;
    pc_load   = 1'b0;
    newpc_in  = 64'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;                                  // nop
    mem[8'h02] = 8'h60; mem[8'h03] = 8'h12;              // addq %rcx,%rdx
    mem[8'h0A] = 8'h30; mem[8'h0B] = 8'hF2; mem[8'h0C] = 8'h05;  // irmovq $5,%rdx
    mem[8'h20] = 8'h30; mem[8'h21] = 8'hF3; mem[8'h22] = 8'h0A;  // irmovq $10,%rbx
    mem[8'h40] = 8'h70; mem[8'h41] = 8'h20;              // jmp 0x20
    mem[8'h50] = 8'hC0;                                  // invalid icode

    // Reset state.
    tick(); tick(); tick();
    check64("rst_pc", pc, 64'h0);
    check64("rst_valid", {63'b0, instr_valid}, 64'd0);
    check64("rst_invalid", {63'b0, instr_invalid}, 64'd0);
    check64("rst_icode", {60'b0, icode}, 64'd0);
    check64("rst_ifun", {60'b0, ifun}, 64'd0);
    check64("rst_rA", {60'b0, rA}, 64'hF);
    check64("rst_rB", {60'b0, rB}, 64'hF);
    check64("rst_valC", valC, 64'h0);
    check64("rst_valP", valP, 64'h0);
    check64("rst_imem_error", {63'b0, imem_error}, 64'd0);

    // nop at RESET_PC, zero-wait memory.
    push_addrs(64'h0, 1);
    reset = 1'b0;
    wait_valid("nop", 10, 1);
    check_fields("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b0, 1'b0);
    check64("nop_pc", pc, 64'h0);
    tick(); tick();
    check64("nop_hold_valid", {63'b0, instr_valid}, 64'd1);
    check64("nop_hold_valP", valP, 64'h1);

    // irmovq at 0x20, zero-wait memory.
    load_pc(64'h20, 10);
    wait_valid("irmovq", 40, 10);
    check_fields("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'h2A, 1'b0, 1'b0);

    // jmp at 0x40, two wait cycles per byte.
    ack_delay = 2;
    load_pc(64'h40, 9);
    wait_valid("jxx", 60, 27);
    check_fields("jxx", 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h49, 1'b0, 1'b0);
    ack_delay = 0;

    // Invalid icode finishes after one byte; next pc_load clears the flags.
    load_pc(64'h50, 1);
    wait_valid("inv", 10, 1);
    check_fields("inv", 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 1'b1, 1'b0);
    load_pc(64'h2, 2);
    wait_valid("opq", 10, 2);
    check_fields("opq", 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h4, 1'b0, 1'b0);

    // Reset during byte 5 of a 10-byte fetch, then a pc_load pulse in FETCH.
    load_pc(64'h20, 5);
    for (int i = 0; i < 5; i++) tick();
    check64("mid_addr", imem_addr, 64'h25);
    check64("mid_valid", {63'b0, instr_valid}, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check64("rst2_addr", imem_addr, 64'h0);
    check64("rst2_req", {63'b0, imem_req}, 64'd1);
    check64("rst2_valid", {63'b0, instr_valid}, 64'd0);
    check64("rst2_pc", pc, 64'h0);
    check64("rst2_valP", valP, 64'h0);
    push_addrs(64'h0, 1);
    pc_load  = 1'b1;
    newpc_in = 64'h40;
    tick();
    pc_load  = 1'b0;
    wait_valid("rst2_nop", 5, 0);
    check_fields("rst2_nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b0, 1'b0);
    check64("rst2_pc_kept", pc, 64'h0);

`ifdef IMEM_BOUND_CHECK_EN
    // irmovq at 0xA crosses the 16-byte memory end.
    load_pc(64'hA, 6);
    wait_valid("bound", 20, 7);
    check_fields("bound", 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'h14, 1'b0, 1'b1);
    load_pc(64'h0, 1);
    check64("bound_err_clear", {63'b0, imem_error}, 64'd0);
    wait_valid("bound_nop", 10, 1);
`endif

    tick(); tick();
    check64("addr_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=still running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
